// File: rtl/atm_multi_ctrl_if.sv
// ----------------------------------------------------------------------------
// atm_multi_ctrl_if
// Purpose : bundles the customer-side strobes/data and the controller status
//           outputs of atm_multi_ctrl into one port.
// Modports: master - the card reader / keypad side (drives requests)
//           slave  - the controller (drives pulses, balance, language, state)
// Signals : incard, acct_id, language, pin/pin_valid, operation/op_valid,
//           amount/amt_valid, confirm, cancel, again/again_valid (requests);
//           incorrectpswd, nobalance, overflow, success, card_locked, timeout
//           (one-cycle pulses), balance_out, lang_out, state_out (status).
// ----------------------------------------------------------------------------
interface atm_multi_ctrl_if #(
    parameter int AW    = 2,
    parameter int PIN_W = 4,
    parameter int AMT_W = 7,
    parameter int BAL_W = 10
);
    // Requests from the customer side
    logic             incard;
    logic [AW-1:0]    acct_id;
    logic             language;
    logic [PIN_W-1:0] pin;
    logic             pin_valid;
    logic [1:0]       operation;
    logic             op_valid;
    logic [AMT_W-1:0] amount;
    logic             amt_valid;
    logic             confirm;
    logic             cancel;
    logic             again;
    logic             again_valid;

    // Status from the controller
    logic             incorrectpswd;
    logic             nobalance;
    logic             overflow;
    logic             success;
    logic             card_locked;
    logic             timeout;
    logic [BAL_W-1:0] balance_out;
    logic             lang_out;
    logic [3:0]       state_out;

    modport master (
        output incard, acct_id, language, pin, pin_valid, operation, op_valid,
               amount, amt_valid, confirm, cancel, again, again_valid,
        input  incorrectpswd, nobalance, overflow, success, card_locked,
               timeout, balance_out, lang_out, state_out
    );

    modport slave (
        input  incard, acct_id, language, pin, pin_valid, operation, op_valid,
               amount, amt_valid, confirm, cancel, again, again_valid,
        output incorrectpswd, nobalance, overflow, success, card_locked,
               timeout, balance_out, lang_out, state_out
    );
endinterface

// File: rtl/atm_multi_ctrl.sv
// ----------------------------------------------------------------------------
// atm_multi_ctrl
// Purpose : multi-account ATM session controller. Holds a balance, PIN, try
//           counter and lock flag per account and walks a card session through
//           IDLE -> LANG -> PIN -> MENU -> (AMOUNT|NEWPIN) -> CONFIRM -> EXEC
//           -> AGAIN. All status pulses are registered and appear the cycle
//           after the decision that caused them.
// Ports   : clock  - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - atm_multi_ctrl_if.slave (requests in, status out)
// Config  : define ATM_TIMEOUT_EN to abort sessions that sit TIMEOUT_CYC
//           cycles in one non-IDLE state; otherwise timeout is tied to 0.
// ----------------------------------------------------------------------------
module atm_multi_ctrl #(
    parameter int               NUM_ACCT    = 4,
    parameter int               PIN_W       = 4,
    parameter int               AMT_W       = 7,
    parameter int               BAL_W       = 10,
    parameter int               MAX_TRIES   = 3,
    parameter logic [PIN_W-1:0] DEFAULT_PIN = PIN_W'(4'b0110),
    parameter logic [BAL_W-1:0] INIT_BAL    = '0,
    parameter int               TIMEOUT_CYC = 64
) (
    input logic             clock,
    input logic             rst_n,
    atm_multi_ctrl_if.slave bus
);
    localparam int AW = (NUM_ACCT > 1) ? $clog2(NUM_ACCT) : 1;
    localparam int TW = $clog2(MAX_TRIES + 1);

    if (NUM_ACCT < 2 || BAL_W < AMT_W || MAX_TRIES < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("atm_multi_ctrl: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_LANG = 4'd1, S_PIN = 4'd2, S_MENU = 4'd3, S_AMOUNT = 4'd4,
        S_CONFIRM = 4'd5, S_EXEC = 4'd6, S_AGAIN = 4'd7, S_NEWPIN = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        OP_DEP = 2'b00, OP_BAL = 2'b01, OP_WDR = 2'b10, OP_PIN = 2'b11
    } op_t;

    state_t              r_state, w_next;
    logic [AW-1:0]       r_acct;
    op_t                 r_op;
    logic [AMT_W-1:0]    r_amount;
    logic [PIN_W-1:0]    r_pend_pin;
    logic [BAL_W-1:0]    r_bal   [NUM_ACCT];
    logic [PIN_W-1:0]    r_pin   [NUM_ACCT];
    logic [TW-1:0]       r_tries [NUM_ACCT];
    logic [NUM_ACCT-1:0] r_lock;
    logic                r_lang, r_lock_evt;
    logic                r_incorrect, r_nobal, r_ovf, r_success, r_locked;
    logic [BAL_W-1:0]    r_balance_out;

    logic [BAL_W-1:0]    w_cur_bal, w_amt_ext, w_new_bal;
    logic [BAL_W:0]      w_sum;
    logic [TW-1:0]       w_tries_inc;
    logic                w_acct_ok, w_timeout_hit;
    logic                w_incorrect, w_nobal, w_ovf, w_success, w_locked;
    logic                w_lock_evt, w_tries_clr, w_tries_bump, w_bal_we, w_pin_we;

    assign w_cur_bal   = r_bal[r_acct];
    assign w_amt_ext   = BAL_W'(r_amount);
    // One extra bit so a deposit that would pass 2^BAL_W-1 is seen, not wrapped.
    assign w_sum       = {1'b0, w_cur_bal} + {1'b0, w_amt_ext};
    assign w_tries_inc = r_tries[r_acct] + 1'b1;
    assign w_acct_ok   = ({1'b0, bus.acct_id} < (AW+1)'(NUM_ACCT));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_next       = r_state;
        w_incorrect  = 1'b0;
        w_nobal      = 1'b0;
        w_ovf        = 1'b0;
        w_success    = 1'b0;
        w_locked     = r_lock_evt;   // lock event from PIN surfaces one cycle later, in IDLE
        w_lock_evt   = 1'b0;
        w_tries_clr  = 1'b0;
        w_tries_bump = 1'b0;
        w_bal_we     = 1'b0;
        w_pin_we     = 1'b0;
        w_new_bal    = w_cur_bal;

        if (r_state != S_IDLE && !bus.incard) begin
            w_next = S_IDLE;             // card pulled: abandon session, nothing commits
        end else if (w_timeout_hit) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (bus.incard && w_acct_ok) begin
                    if (r_lock[bus.acct_id]) w_locked = 1'b1;
                    else                     w_next   = S_LANG;
                end
                S_LANG: w_next = S_PIN;
                S_PIN: if (bus.pin_valid) begin
                    if (bus.pin == r_pin[r_acct]) begin
                        w_tries_clr = 1'b1;
                        w_next      = S_MENU;
                    end else begin
                        w_incorrect  = 1'b1;
                        w_tries_bump = 1'b1;
                        if (w_tries_inc == TW'(MAX_TRIES)) begin
                            w_lock_evt = 1'b1;
                            w_next     = S_IDLE;
                        end
                    end
                end
                S_MENU: if (bus.op_valid) begin
                    case (op_t'(bus.operation))
                        OP_BAL:  w_next = S_CONFIRM;
                        OP_PIN:  w_next = S_NEWPIN;
                        default: w_next = S_AMOUNT;
                    endcase
                end
                S_AMOUNT: if (bus.amt_valid) w_next = S_CONFIRM;
                S_NEWPIN: if (bus.pin_valid) w_next = S_CONFIRM;
                S_CONFIRM: begin
                    if (bus.cancel)       w_next = S_MENU;
                    else if (bus.confirm) w_next = S_EXEC;
                end
                S_EXEC: begin
                    w_next = S_AGAIN;
                    case (r_op)
                        OP_DEP: if (!w_sum[BAL_W]) begin
                            w_success = 1'b1;
                            w_bal_we  = 1'b1;
                            w_new_bal = w_sum[BAL_W-1:0];
                        end else begin
                            w_ovf = 1'b1;
                        end
                        OP_WDR: if (w_amt_ext <= w_cur_bal) begin
                            w_success = 1'b1;
                            w_bal_we  = 1'b1;
                            w_new_bal = w_cur_bal - w_amt_ext;
                        end else begin
                            w_nobal = 1'b1;
                        end
                        OP_BAL:  w_success = 1'b1;
                        default: begin
                            w_success = 1'b1;
                            w_pin_we  = 1'b1;
                        end
                    endcase
                end
                S_AGAIN: if (bus.again_valid) w_next = bus.again ? S_MENU : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the account arrays are reset explicitly; each account must restart from known balance, PIN, tries and lock.
            for (int i = 0; i < NUM_ACCT; i++) begin
                r_bal[i]   <= INIT_BAL;
                r_pin[i]   <= DEFAULT_PIN;
                r_tries[i] <= '0;
            end
            r_lock        <= '0;
            r_acct        <= '0;
            r_op          <= OP_DEP;
            r_amount      <= '0;
            r_pend_pin    <= '0;
            r_lang        <= 1'b0;
            r_lock_evt    <= 1'b0;
            r_incorrect   <= 1'b0;
            r_nobal       <= 1'b0;
            r_ovf         <= 1'b0;
            r_success     <= 1'b0;
            r_locked      <= 1'b0;
            r_balance_out <= '0;
        end else begin
            r_incorrect <= w_incorrect;
            r_nobal     <= w_nobal;
            r_ovf       <= w_ovf;
            r_success   <= w_success;
            r_locked    <= w_locked;
            r_lock_evt  <= w_lock_evt;

            // Session latches; stale values from an aborted session are never used.
            if (r_state == S_IDLE)                     r_acct     <= bus.acct_id;
            if (r_state == S_LANG)                     r_lang     <= bus.language;
            if (r_state == S_MENU   && bus.op_valid)   r_op       <= op_t'(bus.operation);
            if (r_state == S_AMOUNT && bus.amt_valid)  r_amount   <= bus.amount;
            if (r_state == S_NEWPIN && bus.pin_valid)  r_pend_pin <= bus.pin;

            if (w_tries_clr)  r_tries[r_acct] <= '0;
            if (w_tries_bump) r_tries[r_acct] <= w_tries_inc;
            if (w_lock_evt)   r_lock[r_acct]  <= 1'b1;
            if (w_bal_we)     r_bal[r_acct]   <= w_new_bal;
            if (w_pin_we)     r_pin[r_acct]   <= r_pend_pin;
            if (w_success)    r_balance_out   <= w_new_bal;
        end
    end

`ifdef ATM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_tmo_cnt;
    logic          r_timeout;

    // Fires on the TIMEOUT_CYC-th consecutive cycle in one non-IDLE state.
    assign w_timeout_hit = (r_state != S_IDLE) && bus.incard &&
                           (r_tmo_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if (r_state == S_IDLE || w_next != r_state) r_tmo_cnt <= '0;
            else                                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign bus.timeout   = 1'b0;
`endif

    assign bus.incorrectpswd = r_incorrect;
    assign bus.nobalance     = r_nobal;
    assign bus.overflow      = r_ovf;
    assign bus.success       = r_success;
    assign bus.card_locked   = r_locked;
    assign bus.balance_out   = r_balance_out;
    assign bus.lang_out      = r_lang;
    assign bus.state_out     = r_state;
endmodule
